seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for the 8-digit seven-segment display. It shares the single 4-bit-code segment decoder between eight digit positions. Each step it selects one digit, drives that digit's code onto the decoder input, and moves on. Per-digit blanking, blinking (for settings edit) and leading-zero suppression are applied by substituting the blank code. Codes follow the decoder: 0x0–0x9 digits, 0xA minus sign, 0xB blank.

## Interface
- SCAN_DIV, 100000: clock cycles each digit stays selected (1 ms at 100 MHz); legal range ≥ 2.
- BLINK_FRAMES, 62: complete 8-digit frames per blink half-period; legal range ≥ 1.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- digits  in  32  digit i code in bits [4i+3:4i]; digit 0 is rightmost.
- blank_mask  in  8  bit i = 1 forces digit i blank.
- blink_mask  in  8  bit i = 1 blanks digit i during the blink-off phase.
- lz_en  in  1  enables leading-zero suppression.
- num  out  4  code to the segment decoder.
- dig_sel  out  8  one-hot digit enable, active-high; bit i = digit i.
- frame_done  out  1  one-cycle pulse at the end of each 8-digit frame.

## Operation
- Registers:
  - tick: clog2(SCAN_DIV) bits, counts 0..SCAN_DIV-1.
  - ptr: 3 bits, current digit.
  - fcnt: counts frames, 0..BLINK_FRAMES-1.
  - blink_phase: 0 = visible, 1 = off.
  - Snapshot registers snap_digits, snap_blank, snap_blink, snap_lz.
- tick increments every cycle. At SCAN_DIV-1 it wraps to 0 and ptr increments, with ptr wrapping from 7 to 0.
- Snapshot loads from the inputs on every cycle where tick==0 and ptr==0 (frame start). Inputs are ignored at all other times, so there is no tearing mid-frame.
- The displayed code for digit i is computed only from snapshot registers. It is 0xB if any of these holds, otherwise snap_digits[i]:
  - snap_blank[i] is 1.
  - snap_blink[i] is 1 and blink_phase is 1.
  - Digit i is a suppressed leading zero.
- Leading-zero rule: digit i is suppressed only when all of the following hold. Digit 0 is never suppressed.
  - snap_lz is 1.
  - i ≥ 1.
  - Its code is 0x0.
  - Every digit j > i is either suppressed itself or has effective code 0xB (blanked by mask or code).
- Leading-zero suppression consequences:
  - 0xA (minus) counts as non-zero and stops suppression.
  - Blink-off does not count as blank for this rule, so digit positions stay stable while blinking.
- Codes 0xC–0xF pass through unchanged; the decoder renders them dark.
- Blink phase:
  - fcnt increments on each frame end (tick==SCAN_DIV-1 and ptr==7).
  - When fcnt==BLINK_FRAMES-1 at a frame end, fcnt goes to 0 and blink_phase toggles.

## Timing
- Reset values (while rst_n is low at a clock edge):
  - Outputs: num=0xB, dig_sel=8'h00, frame_done=0.
  - Internal: tick=0, ptr=0, fcnt=0, blink_phase=0, snap_digits=32'hBBBB_BBBB, snap masks=0, snap_lz=0.
- Outputs are registered and derive from the pre-edge ptr/snapshot. dig_sel and num therefore change together, one cycle after ptr changes.
- dig_sel never has more than one bit set. It is never 0 outside reset and the first cycle after reset.
- First edge after rst_n rises: snapshot loads and dig_sel becomes 8'h01. num is still 0xB because the pre-edge snapshot was blank. From the second edge on, num shows digit 0's code.
- Digit k is selected for exactly SCAN_DIV consecutive cycles, and a frame lasts 8·SCAN_DIV cycles.
- frame_done is high for exactly one cycle. It is the cycle after the edge where tick==SCAN_DIV-1 and ptr==7, which coincides with the snapshot-load cycle of the next frame.
- blink_phase toggles every BLINK_FRAMES frames, so a full blink period is 2·BLINK_FRAMES frames.
- If rst_n goes low mid-frame, the next edge returns every register to its reset value. Scanning then restarts at digit 0 with a new snapshot.
- Input changes take effect at the next frame start. Worst-case latency to display is 8·SCAN_DIV+1 cycles.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_FRAMES=2.
- Scan order: digits=32'h7654_3210, masks=0, lz_en=0, reset then release.
  - dig_sel steps 01,02,04,…,80,01 every 4 cycles.
  - num reads 0,1,…,7 aligned with dig_sel.
  - frame_done pulses every 32 cycles.
- Leading zero: digits=32'h0000_0A05, lz_en=1.
  - Digits 7..3 read 0xB; digit 2 reads 0xA, digit 1 reads 0x0, digit 0 reads 0x5.
  - With digits=0, digit 0 reads 0x0 and all others read 0xB.
- Blink: digits=32'h1111_1111, blink_mask=8'h03.
  - Digits 0–1 read 0x1 for 2 frames, then 0xB for 2 frames, repeating.
  - Digits 2–7 always read 0x1.
- Snapshot: change digits from 32'h1111_1111 to 32'h2222_2222 while ptr=3.
  - The remainder of the frame still reads 0x1.
  - The next frame reads 0x2.
- Reset mid-frame: assert rst_n low for 1 edge while ptr=5.
  - Outputs become num=0xB and dig_sel=00.
  - After release, dig_sel=01 on the first edge, and digit 0's code appears on the second edge.
- blank_mask=8'hFF: num is 0xB every cycle, while dig_sel continues scanning.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: per-digit code mux with
// frame snapshot, blanking, blinking and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  blink_mask,
  input  logic        lz_en,
  output logic [3:0]  num,
  output logic [7:0]  dig_sel,
  output logic        frame_done
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick;
  logic [2:0]    ptr;
  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic [31:0]   snap_digits;
  logic [7:0]    snap_blank;
  logic [7:0]    snap_blink;
  logic          snap_lz;

  logic       wrap;
  logic       fstart;
  logic       fend;
  logic [7:0] sup;
  logic [3:0] cur;
  logic       hide;
  logic [3:0] nxt_num;

  assign wrap   = (tick == TMAX);
  assign fstart = (tick == '0) && (ptr == 3'd0);
  assign fend   = wrap && (ptr == 3'd7);

  // keep stays set while every digit above i is suppressed or blank
  always_comb begin
    logic keep;
    logic eb;
    sup  = '0;
    keep = snap_lz;
    for (int i = 7; i >= 1; i--) begin
      eb     = snap_blank[i] || (snap_digits[4*i +: 4] == 4'hB);
      sup[i] = keep && (snap_digits[4*i +: 4] == 4'h0);
      keep   = keep && (sup[i] || eb);
    end
  end

  always_comb begin
    cur     = snap_digits[{ptr, 2'b00} +: 4];
    hide    = snap_blank[ptr]
            || (snap_blink[ptr] && blink_phase)
            || sup[ptr];
    nxt_num = hide ? 4'hB : cur;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick        <= '0;
      ptr         <= 3'd0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      snap_digits <= 32'hBBBB_BBBB;
      snap_blank  <= 8'h00;
      snap_blink  <= 8'h00;
      snap_lz     <= 1'b0;
      num         <= 4'hB;
      dig_sel     <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      tick <= wrap ? '0 : tick + 1'b1;
      if (wrap) ptr <= ptr + 3'd1;
      if (fstart) begin
        snap_digits <= digits;
        snap_blank  <= blank_mask;
        snap_blink  <= blink_mask;
        snap_lz     <= lz_en;
      end
      if (fend) begin
        if (fcnt == FMAX) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      dig_sel    <= 8'h01 << ptr;
      num        <= nxt_num;
      frame_done <= fend;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
// Vector table for static frames plus blink, snapshot and reset sequences.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] digits;
  logic [7:0]  blank_mask;
  logic [7:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  num;
  logic [7:0]  dig_sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .lz_en     (lz_en),
    .num       (num),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  bm;
    logic [7:0]  km;
    logic        lz;
    logic [31:0] exp;
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    edge1();
    chk("rst_num", num, 4'hB);
    chk("rst_sel", dig_sel, 8'h00);
    chk("rst_fd", frame_done, 1'b0);
    edge1();
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [31:0] d, input logic [7:0] bm,
                        input logic [7:0] km, input logic lz);
    digits     = d;
    blank_mask = bm;
    blink_mask = km;
    lz_en      = lz;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    int k;
    int f;
    vec[0] = '{32'h7654_3210, 8'h00, 8'h00, 1'b0, 32'h7654_3210};
    vec[1] = '{32'h0000_0A05, 8'h00, 8'h00, 1'b1, 32'hBBBB_BA05};
    vec[2] = '{32'h0000_0000, 8'h00, 8'h00, 1'b1, 32'hBBBB_BBB0};
    vec[3] = '{32'h7654_3210, 8'hFF, 8'h00, 1'b0, 32'hBBBB_BBBB};
    vec[4] = '{32'h0000_0000, 8'h00, 8'h00, 1'b0, 32'h0000_0000};
    vec[5] = '{32'h00B0_0300, 8'h00, 8'h00, 1'b1, 32'hBBBB_B300};
    vec[6] = '{32'h0500_0007, 8'h40, 8'h00, 1'b1, 32'hBBBB_BBB7};
    vec[7] = '{32'hFEDC_BA98, 8'h00, 8'h00, 1'b1, 32'hFEDC_BA98};
    vec[8] = '{32'h1111_1111, 8'h00, 8'h03, 1'b0, 32'h1111_1111};
    vec[9] = '{32'hA000_0000, 8'h00, 8'h00, 1'b1, 32'hA000_0000};

    set_in(32'h0, 8'h0, 8'h0, 1'b0);
    rst_n = 1'b0;

    // static frames: one frame per vector after a fresh reset
    for (int v = 0; v < 10; v++) begin
      set_in(vec[v].d, vec[v].bm, vec[v].km, vec[v].lz);
      do_reset();
      for (int n = 1; n <= 32; n++) begin
        edge1();
        if (n == 1) begin
          chk("first_sel", dig_sel, 8'h01);
          chk("first_num", num, 4'hB);
        end
        chk("fdone", frame_done, (n == 32));
        if (n % 4 == 3) begin
          k = n / 4;
          e = vec[v].exp >> (4 * k);
          chk("sel", dig_sel, 8'h01 << k);
          chk("num", num, e[3:0]);
        end
      end
    end

    // blink: two frames visible, two frames off on digits 0-1
    set_in(32'h1111_1111, 8'h00, 8'h03, 1'b0);
    do_reset();
    for (int n = 1; n <= 192; n++) begin
      edge1();
      chk("blink_fd", frame_done, (n % 32 == 0));
      if (n % 4 == 3) begin
        k = ((n - 1) / 4) % 8;
        f = (n - 1) / 32;
        e = (k < 2 && (f / 2) % 2 == 1) ? 32'hB : 32'h1;
        chk("blink_sel", dig_sel, 8'h01 << k);
        chk("blink_num", num, e);
      end
    end

    // snapshot: change input while digit 3 is scanned
    set_in(32'h1111_1111, 8'h00, 8'h00, 1'b0);
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      edge1();
      if (n == 14) digits = 32'h2222_2222;
      if (n % 4 == 3) begin
        e = (n <= 32) ? 32'h1 : 32'h2;
        chk("snap_num", num, e);
      end
    end

    // reset while digit 5 is selected
    set_in(32'h7654_3210, 8'h00, 8'h00, 1'b0);
    do_reset();
    for (int n = 1; n <= 22; n++) edge1();
    chk("mid_sel5", dig_sel, 8'h20);
    chk("mid_num5", num, 4'h5);
    rst_n  = 1'b0;
    digits = 32'h7654_3219;
    edge1();
    chk("mid_rst_num", num, 4'hB);
    chk("mid_rst_sel", dig_sel, 8'h00);
    chk("mid_rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    edge1();
    chk("mid_e1_sel", dig_sel, 8'h01);
    chk("mid_e1_num", num, 4'hB);
    edge1();
    chk("mid_e2_sel", dig_sel, 8'h01);
    chk("mid_e2_num", num, 4'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
